// File: rtl/alu_flag_gen.sv
// Multi-cycle 16-bit ALU with registered result and C/Z/N/V flags.
// Shifts run one bit per clock; every other opcode completes in a single EXEC cycle.
module alu_flag_gen #(
    parameter int DATA_W = 16,
    parameter int FLAG_W = 4
) (
    input  logic              clock,
    input  logic              n_rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [FLAG_W-1:0] flags,
    output logic              flag_we
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [3:0]        count_q, count_d;
    logic              shc_q, shc_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [DATA_W:0]   sum_s;
    logic [DATA_W-1:0] diff_s;
    logic [DATA_W-1:0] res_s;
    logic              c_s;
    logic              v_s;
    logic              is_shift_s;

    // Arithmetic/logic datapath on the latched operands; a_q doubles as the shift working value.
    always_comb begin
        sum_s  = {1'b0, a_q} + {1'b0, b_q};
        diff_s = a_q - b_q;
        res_s  = {DATA_W{1'b0}};
        c_s    = 1'b0;
        v_s    = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_s = sum_s[DATA_W-1:0];
                c_s   = sum_s[DATA_W];
                v_s   = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (sum_s[DATA_W-1] != a_q[DATA_W-1]);
            end
            OP_SUB, OP_CMP: begin
                res_s = diff_s;
                c_s   = (a_q < b_q);
                v_s   = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (diff_s[DATA_W-1] != a_q[DATA_W-1]);
            end
            OP_AND: res_s = a_q & b_q;
            OP_OR:  res_s = a_q | b_q;
            OP_XOR: res_s = a_q ^ b_q;
            OP_SHL, OP_SHR: begin
                res_s = a_q;
                c_s   = shc_q;
            end
            default: res_s = {DATA_W{1'b0}};
        endcase
    end

    assign is_shift_s = (op_q == OP_SHL) || (op_q == OP_SHR);

    // Next-state, operand latch, shift sequencing and result/flag capture.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        count_d  = count_q;
        shc_d    = shc_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    count_d = b[3:0];
                    shc_d   = 1'b0;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (is_shift_s && (count_q != 4'd0)) begin
                    if (op_q == OP_SHL) begin
                        shc_d = a_q[DATA_W-1];
                        a_d   = a_q << 1;
                    end else begin
                        shc_d = a_q[0];
                        a_d   = a_q >> 1;
                    end
                    count_d = count_q - 4'd1;
                end else begin
                    // CMP only updates flags; the previous result is kept.
                    if (op_q == OP_CMP) begin
                        result_d = result_q;
                    end else begin
                        result_d = res_s;
                    end
                    flags_d = {v_s, res_s[DATA_W-1], (res_s == {DATA_W{1'b0}}), c_s};
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_EXEC) || (state_d == ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers; reset aborts any in-flight operation.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ST_IDLE;
            op_q     <= 3'b000;
            a_q      <= {DATA_W{1'b0}};
            b_q      <= {DATA_W{1'b0}};
            count_q  <= 4'd0;
            shc_q    <= 1'b0;
            result_q <= {DATA_W{1'b0}};
            flags_q  <= {FLAG_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            count_q  <= count_d;
            shc_q    <= shc_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign flag_we = done_q;
    assign result  = result_q;
    assign flags   = flags_q;

endmodule

// File: doc/alu_flag_gen.md
ALU_FLAG_GEN -- requirements
Module: alu_flag_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand/result width; only 16 is supported.
REQ-002 SHALL have parameter FLAG_W, default 4, flag vector width; only 4 is supported.
REQ-003 SHALL have port clock, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, operation request; sampled only in IDLE.
REQ-006 SHALL have port op, input, 3, opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 CMP.
REQ-007 SHALL have port a, input, DATA_W, first operand.
REQ-008 SHALL have port b, input, DATA_W, second operand; for SHL/SHR only b[3:0] is used, as the shift count.
REQ-009 SHALL have port busy, output, 1, high in EXEC and DONE states.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port result, output, DATA_W, registered result; holds its value between operations.
REQ-012 SHALL have port flags, output, FLAG_W, registered flags: [0]=C, [1]=Z, [2]=N, [3]=V; holds its value between operations.
REQ-013 SHALL have port flag_we, output, 1, flag-register write strobe; equal to done.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC and DONE.
REQ-015 SHALL, in IDLE with start=1 at edge E0, latch a, b, op and count=b[3:0], then enter EXEC.
REQ-016 SHALL ignore start in EXEC and DONE; latched operands SHALL NOT change.
REQ-017 SHALL, in EXEC for SHL/SHR with count!=0, shift the working value one bit per edge (zero fill), record the shifted-out bit, decrement count, and remain in EXEC.
REQ-018 SHALL, in EXEC for any other op, or for a shift with count==0, register result and flags, then enter DONE.
REQ-019 SHALL assert done and flag_we for exactly the DONE cycle, then return to IDLE on the next edge.
REQ-020 SHALL give latency E0 to done of 1 edge for non-shift ops and for shift count 0, and n+1 edges for shift count n (max 16 edges).
REQ-021 SHALL use 16-bit wrap-around arithmetic: ADD = a+b, SUB/CMP = a-b.
REQ-022 SHALL set Z=1 iff the 16-bit computed value is 0, and N = bit 15 of the computed value.
REQ-023 SHALL set C as follows: ADD = carry-out; SUB/CMP = 1 iff a<b unsigned (borrow); SHL/SHR = last shifted-out bit (0 when count=0); AND/OR/XOR = 0.
REQ-024 SHALL set V as follows: ADD/SUB/CMP = signed overflow; all other ops = 0.
REQ-025 SHALL, for CMP, update flags and pulse flag_we but leave result unchanged.
REQ-026 SHALL allow start to be accepted in the IDLE cycle immediately following DONE (back-to-back throughput: 1 op per 3 cycles minimum).

Reset
REQ-027 SHALL, while n_rst=0, force state=IDLE, busy=0, done=0, flag_we=0, result=0x0000, flags=0x0, count=0, independent of clock.
REQ-028 SHALL abort any in-flight operation on reset with no done pulse, and accept new starts from the first edge after n_rst deasserts.

Verification
REQ-029 SHALL cover ADD a=0x7FFF, b=0x0001 -> result 0x8000, flags V=1 N=1 Z=0 C=0 (0xC); done/flag_we high one cycle after E1.
REQ-030 SHALL cover SUB a=0x0003, b=0x0005 -> result 0xFFFE, C=1 N=1 Z=0 V=0 (0x5); then CMP a=b=0x1234 -> flags Z=1 (0x2), result stays 0xFFFE, flag_we pulses.
REQ-031 SHALL cover SHL a=0xC001, b=0x0002 -> result 0x0004, C=1 (0x1); busy for 3 cycles and done after E3; SHR a=0x00F0, b=0x0000 -> result 0x00F0, C=0, done after E1.
REQ-032 SHALL cover start pulsed with SHR a=0xFFFF, b=0x000F, then start with ADD re-pulsed during EXEC -> second request ignored; result 0x0001, C=1 after 16 edges; exactly one done.
REQ-033 SHALL cover n_rst driven low mid-SHL (count=8, after 3 shifts) -> busy/done/flag_we=0, result=0x0000, flags=0x0 immediately; no done afterwards; next ADD 0x0001+0x0001 -> 0x0002, flags 0x0.
REQ-034 SHALL cover AND a=0x0F0F, b=0xF0F0 -> result 0x0000, Z=1 only (0x2); XOR a=0x8000, b=0x0000 -> 0x8000, N=1 only (0x4).
